axim_read_control: RTL and testbench
====================================

# axim_read_control

AXI read-channel initiator that pairs with the SDRAM write test generator on the memory interface. On a rising edge of an asynchronous start request it issues one INCR read burst of 32 16-bit words starting at word address 0. It checks each returned word against the write pattern (100, 101, …, 131) and reports pass/fail and an error count. It sits beside the write control on the memif AXI port and lets the board confirm SDRAM round-trip integrity.

## Interface
- BURST_SIZE, 32: beats per burst, range 1–256; arlen = BURST_SIZE-1.
- START_DATA, 16'd100: expected value of beat 0; beat k expects START_DATA+k, modulo 2^16.
- BASE_ADDR, 25'd0: word address driven on araddr.
- clk in 1: single clock; all logic rises on it.
- reset in 1: asynchronous, active-low; all state and outputs clear immediately when low.
- start_triger in 1: asynchronous start request; a rising edge starts one check.
- axi_arready_in in 1: address ready from the slave.
- axi_arvalid_out out 1: address valid; reset 0.
- axi_arlen_out out 8: BURST_SIZE-1, constant, including during reset.
- axi_araddr_out out 25: BASE_ADDR, constant.
- axi_rvalid_in in 1: read data valid.
- axi_rdata_in in 16: read data.
- axi_rlast_in in 1: last beat marker.
- axi_rresp_in in 1: 0=OKAY, 1=error.
- axi_rready_out out 1: read ready; reset 0.
- busy_out out 1: high from AR issue until the burst completes; reset 0.
- done_out out 1: one-cycle pulse on completion; reset 0.
- pass_out out 1: result of the last completed check, held until the next start; reset 0.
- err_count_out out 8: count of mismatched or error-response beats, saturating at 255; reset 0.
- proto_err_out out 1: rlast placement error in the last check; reset 0.

## Operation
- Start detection: start_triger passes through a 3-flop chain (meta, 1d, 2d). A start is detected when 1d & ~2d.
- States:
  - IDLE: outputs quiescent. On a detected start, clear err_count, proto_err and pass, set beat_cnt=0, assert arvalid and busy, and go to ADDR.
  - ADDR: hold arvalid until arready=1. On that edge, drop arvalid, assert rready, and go to DATA.
  - DATA: rready is held high. Each edge with rvalid=1 is an accepted beat.
    - Compare rdata against START_DATA+beat_cnt. A mismatch, or rresp=1, increments err_count (saturating).
    - rlast=1 on a beat other than beat BURST_SIZE-1 sets proto_err and ends the burst at that beat.
    - Beat BURST_SIZE-1 received without rlast sets proto_err and ends the burst anyway.
    - On the ending beat: drop rready and busy, pulse done, set pass = (err_count after this beat == 0) & ~proto_err, and return to IDLE.
- A start detected while busy is ignored; it is not queued.
- rvalid outside DATA is ignored, since rready=0.
- Reset mid-burst aborts immediately; outputs go to their reset values. Beats the slave is still holding are not drained.
- beat_cnt is 8 bits. The expected value is START_DATA + beat_cnt, truncated to 16 bits, so FFFF wraps to 0000.

## Timing
- start_triger first sampled 1 at edge N: arvalid=1 after edge N+2. busy rises on the same edge.
- AR handshake at edge M (arvalid & arready): arvalid=0 and rready=1 after M.
- A beat is consumed on every edge where rvalid=1 in DATA. Throughput is one beat per clock with no bubbles.
- Final beat accepted at edge L: after L, done=1 for exactly one cycle, pass, err_count and proto_err are valid and stable, and rready=0 and busy=0.
- The earliest next start detection is one cycle after L.
- err_count and pass change only at beat edges and on start.

## Structure
- Package axi_memif_pkg holds BURST_SIZE, START_DATA and BASE_ADDR defaults and the read state encoding (IDLE/ADDR/DATA). The write control shares the same constants so the pattern stays consistent.
- Sub-module start_sync_edge holds the 3-flop synchroniser and rising-edge detector, with a one-cycle pulse output. The write control reuses it.

## Test plan
- Nominal read: start, arready after 2 cycles, slave returns 100…131 back-to-back with rlast on beat 31. Expected: arlen=31, araddr=0, done pulse after beat 31, pass=1, err_count=0, proto_err=0.
- Corrupted data: beats 5 and 20 return 0 instead of 105 and 120, and beat 7 returns rresp=1. Expected: err_count=3, pass=0.
- rvalid gaps: rvalid is low every other cycle. Expected: all 32 beats accepted, pass=1, and done is delayed to the edge after the 32nd beat.
- Protocol errors: rlast on beat 15 ends the burst with proto_err=1, pass=0, rready=0. In a second run, no rlast on beat 31 still ends the burst with proto_err=1.
- Start handling: a second start_triger edge during DATA produces no new AR. reset low at beat 10 clears arvalid, rready, busy and err_count, and a start after release completes normally.
- Wrap and saturation: START_DATA=16'hFFF0 with BURST_SIZE=32 expects a wrap to 0000 at beat 16. BURST_SIZE=256 with all beats wrong gives err_count=255.

Source files
------------

// File: rtl/axi_memif_pkg.sv
// Shared constants and read-state encoding for the memif AXI read/write controllers.
// The write control uses the same pattern constants so both sides agree on the data.
package axi_memif_pkg;

    localparam int unsigned BURST_SIZE_DEF = 32;
    localparam logic [15:0] START_DATA_DEF = 16'd100;
    localparam logic [24:0] BASE_ADDR_DEF  = 25'd0;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Three-flop synchroniser for an asynchronous start request with a rising-edge pulse.
// The pulse is combinational from the 1d/2d flops, so it is valid the cycle after 1d rises.
module start_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_1d;
    logic r_2d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_1d   <= 1'b0;
            r_2d   <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_1d   <= r_meta;
            r_2d   <= r_1d;
        end
    end

    assign o_pulse = r_1d & ~r_2d;

endmodule

// File: rtl/axim_read_control.sv
// AXI read initiator: issues one INCR burst and checks it against the write test pattern.
// Reports pass/fail, a saturating error count and an rlast placement error.
//
// state   | meaning
// RD_IDLE | quiescent, waiting for a synchronised start edge
// RD_ADDR | arvalid held until the slave accepts the address
// RD_DATA | rready high, checking one beat per rvalid edge
module axim_read_control
    import axi_memif_pkg::*;
#(
    parameter int unsigned BURST_SIZE = BURST_SIZE_DEF,
    parameter logic [15:0] START_DATA = START_DATA_DEF,
    parameter logic [24:0] BASE_ADDR  = BASE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_triger,
    input  logic        axi_arready_in,
    output logic        axi_arvalid_out,
    output logic [7:0]  axi_arlen_out,
    output logic [24:0] axi_araddr_out,
    input  logic        axi_rvalid_in,
    input  logic [15:0] axi_rdata_in,
    input  logic        axi_rlast_in,
    input  logic        axi_rresp_in,
    output logic        axi_rready_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        pass_out,
    output logic [7:0]  err_count_out,
    output logic        proto_err_out
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_SIZE - 1);

    rd_state_t   r_state, w_state_nxt;
    logic        r_arvalid, w_arvalid_nxt;
    logic        r_rready, w_rready_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_pass, w_pass_nxt;
    logic [7:0]  r_err_cnt, w_err_nxt;
    logic        r_proto_err, w_proto_nxt;
    logic [7:0]  r_beat_cnt, w_beat_nxt;

    logic        w_start;
    logic [15:0] w_expected;
    logic        w_beat_bad;
    logic [7:0]  w_err_inc;
    logic        w_last_idx;
    logic        w_misplaced;

    start_sync_edge u_start_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (start_triger),
        .o_pulse (w_start)
    );

    // Expected data is truncated to 16 bits so the pattern wraps FFFF -> 0000.
    assign w_expected  = START_DATA + {8'd0, r_beat_cnt};
    assign w_beat_bad  = (axi_rdata_in != w_expected) | axi_rresp_in;
    assign w_err_inc   = w_beat_bad ? sat_inc8(r_err_cnt) : r_err_cnt;
    assign w_last_idx  = (r_beat_cnt == LAST_BEAT);
    assign w_misplaced = axi_rlast_in ^ w_last_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RD_IDLE;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_proto_err <= 1'b0;
            r_beat_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_cnt   <= w_err_nxt;
            r_proto_err <= w_proto_nxt;
            r_beat_cnt  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = r_pass;
        w_err_nxt     = r_err_cnt;
        w_proto_nxt   = r_proto_err;
        w_beat_nxt    = r_beat_cnt;
        case (r_state)
            RD_IDLE: begin
                if (w_start) begin
                    w_err_nxt     = 8'd0;
                    w_proto_nxt   = 1'b0;
                    w_pass_nxt    = 1'b0;
                    w_beat_nxt    = 8'd0;
                    w_arvalid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi_arready_in) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid_in) begin
                    w_err_nxt  = w_err_inc;
                    w_beat_nxt = r_beat_cnt + 8'd1;
                    // Early rlast or a missing rlast on the final beat both end the burst here.
                    if (axi_rlast_in || w_last_idx) begin
                        w_proto_nxt  = w_misplaced;
                        w_pass_nxt   = (w_err_inc == 8'd0) && !w_misplaced;
                        w_done_nxt   = 1'b1;
                        w_rready_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_state_nxt  = RD_IDLE;
                    end
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    assign axi_arvalid_out = r_arvalid;
    assign axi_arlen_out   = LAST_BEAT;
    assign axi_araddr_out  = BASE_ADDR;
    assign axi_rready_out  = r_rready;
    assign busy_out        = r_busy;
    assign done_out        = r_done;
    assign pass_out        = r_pass;
    assign err_count_out   = r_err_cnt;
    assign proto_err_out   = r_proto_err;

endmodule

// File: tb/tb_axim_read_control.sv
// Bench for axim_read_control: a default instance and a 256-beat instance whose pattern wraps.
// Bursts are described as beat tables; expectations come from the pattern and rlast rules.
module tb_axim_read_control;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st0, st1;
    logic        arready, rvalid, rlast, rresp;
    logic [15:0] rdata;

    logic        arvalid0, rready0, busy0, done0, pass0, proto0;
    logic        arvalid1, rready1, busy1, done1, pass1, proto1;
    logic [7:0]  arlen0, arlen1, err0, err1;
    logic [24:0] araddr0, araddr1;

    axim_read_control u_dut0 (
        .clk(clk), .reset(reset), .start_triger(st0),
        .axi_arready_in(arready), .axi_arvalid_out(arvalid0),
        .axi_arlen_out(arlen0), .axi_araddr_out(araddr0),
        .axi_rvalid_in(rvalid), .axi_rdata_in(rdata),
        .axi_rlast_in(rlast), .axi_rresp_in(rresp),
        .axi_rready_out(rready0), .busy_out(busy0), .done_out(done0),
        .pass_out(pass0), .err_count_out(err0), .proto_err_out(proto0)
    );

    axim_read_control #(.BURST_SIZE(256), .START_DATA(16'hFFF0)) u_dut1 (
        .clk(clk), .reset(reset), .start_triger(st1),
        .axi_arready_in(arready), .axi_arvalid_out(arvalid1),
        .axi_arlen_out(arlen1), .axi_araddr_out(araddr1),
        .axi_rvalid_in(rvalid), .axi_rdata_in(rdata),
        .axi_rlast_in(rlast), .axi_rresp_in(rresp),
        .axi_rready_out(rready1), .busy_out(busy1), .done_out(done1),
        .pass_out(pass1), .err_count_out(err1), .proto_err_out(proto1)
    );

    int sel = 0;
    logic       m_arvalid, m_rready, m_busy, m_done, m_pass, m_proto;
    logic [7:0] m_err;
    assign m_arvalid = (sel != 0) ? arvalid1 : arvalid0;
    assign m_rready  = (sel != 0) ? rready1  : rready0;
    assign m_busy    = (sel != 0) ? busy1    : busy0;
    assign m_done    = (sel != 0) ? done1    : done0;
    assign m_pass    = (sel != 0) ? pass1    : pass0;
    assign m_proto   = (sel != 0) ? proto1   : proto0;
    assign m_err     = (sel != 0) ? err1     : err0;

    int checks = 0;
    int errors = 0;

    logic [15:0] b_data [256];
    logic        b_resp [256];
    logic        b_last [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bs();
        return (sel != 0) ? 256 : 32;
    endfunction

    function automatic logic [15:0] sd();
        return (sel != 0) ? 16'hFFF0 : 16'd100;
    endfunction

    task automatic set_start(input logic v);
        if (sel != 0) st1 = v;
        else          st0 = v;
    endtask

    task automatic fill_good();
        for (int k = 0; k < 256; k++) begin
            b_data[k] = 16'(sd() + k);
            b_resp[k] = 1'b0;
            b_last[k] = (k == bs() - 1);
        end
    endtask

    task automatic fill_random();
        fill_good();
        for (int k = 0; k < bs(); k++) begin
            if ($urandom_range(0, 7) == 0)  b_data[k] = 16'($urandom);
            if ($urandom_range(0, 15) == 0) b_resp[k] = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) b_last[$urandom_range(0, bs() - 1)] = 1'b1;
        if ($urandom_range(0, 3) == 0) b_last[bs() - 1] = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 rvalid low every other cycle, 2 random gaps.
    task automatic run_burst(input int ar_delay, input int gap_mode,
                             input int restart_beat, input int abort_beat);
        int   e_end;
        logic e_proto;
        int   k, cyc, run_cnt;
        bit   fin, gap, found;

        e_end = bs() - 1;
        found = 0;
        for (int i = 0; i < bs(); i++) begin
            if (!found && b_last[i]) begin
                e_end = i;
                found = 1;
            end
        end
        e_proto = !((e_end == bs() - 1) && b_last[bs() - 1]);

        set_start(1'b1);
        @(negedge clk); chk("arvalid_lat1", m_arvalid, 0);
        @(negedge clk); chk("arvalid_lat2", m_arvalid, 0);
        @(negedge clk);
        chk("arvalid_up", m_arvalid, 1);
        chk("busy_up", m_busy, 1);
        chk("start_clr_err", m_err, 0);
        chk("start_clr_pass", m_pass, 0);
        chk("start_clr_proto", m_proto, 0);
        set_start(1'b0);

        // Beats offered before the address handshake must be ignored.
        rvalid = 1'b1; rdata = 16'h5A5A; rlast = 1'b1; rresp = 1'b1;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            chk("arvalid_hold", m_arvalid, 1);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("ar_hs_arvalid", m_arvalid, 0);
        chk("ar_hs_rready", m_rready, 1);
        chk("ar_hs_err", m_err, 0);

        k = 0; cyc = 0; run_cnt = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            if (k == abort_beat) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 1'b0;
                reset = 1'b0;
                #1;
                chk("abort_arvalid", m_arvalid, 0);
                chk("abort_rready", m_rready, 0);
                chk("abort_busy", m_busy, 0);
                chk("abort_err", m_err, 0);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            if (k == restart_beat) set_start(1'b1);
            if (k == restart_beat + 3) set_start(1'b0);
            case (gap_mode)
                1:       gap = cyc[0];
                2:       gap = ($urandom_range(0, 2) == 0);
                default: gap = 0;
            endcase
            rvalid = !gap;
            rdata  = b_data[k];
            rresp  = b_resp[k];
            rlast  = b_last[k];
            @(negedge clk);
            cyc++;
            if (!gap) begin
                if (((b_data[k] != 16'(sd() + k)) || b_resp[k]) && run_cnt < 255) run_cnt++;
                if (k == e_end) begin
                    fin = 1;
                    chk("end_done", m_done, 1);
                    chk("end_rready", m_rready, 0);
                    chk("end_busy", m_busy, 0);
                    chk("end_err", m_err, 32'(run_cnt));
                    chk("end_proto", m_proto, 32'(e_proto));
                    chk("end_pass", m_pass, 32'((run_cnt == 0) && !e_proto));
                end else begin
                    chk("beat_done", m_done, 0);
                    chk("beat_rready", m_rready, 1);
                    chk("beat_err", m_err, 32'(run_cnt));
                    k++;
                end
            end else begin
                chk("gap_done", m_done, 0);
                chk("gap_err", m_err, 32'(run_cnt));
            end
            chk("data_arvalid", m_arvalid, 0);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 1'b0;
        set_start(1'b0);
        chk("burst_finished", 32'(fin), 1);
        @(negedge clk);
        chk("post_done", m_done, 0);
        chk("post_busy", m_busy, 0);
        chk("post_err_held", m_err, 32'(run_cnt));
        chk("post_pass_held", m_pass, 32'((run_cnt == 0) && !e_proto));
        if (restart_beat >= 0) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("no_queued_start", m_arvalid, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; st0 = 1'b0; st1 = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 1'b0; rdata = 16'd0;
        #1;
        chk("rst_arvalid0", arvalid0, 0);
        chk("rst_rready0", rready0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_pass0", pass0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_proto0", proto0, 0);
        chk("rst_arlen0", arlen0, 31);
        chk("rst_arlen1", arlen1, 255);
        chk("rst_araddr0", araddr0, 0);
        chk("rst_araddr1", araddr1, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        sel = 0;
        fill_good();
        run_burst(2, 0, -1, -1);
        chk("nominal_pass", m_pass, 1);
        chk("nominal_arlen", arlen0, 31);

        fill_good();
        b_data[5] = 16'd0; b_data[20] = 16'd0; b_resp[7] = 1'b1;
        run_burst(1, 0, -1, -1);
        chk("corrupt_err", m_err, 3);
        chk("corrupt_pass", m_pass, 0);

        fill_good();
        run_burst(0, 1, -1, -1);
        chk("gaps_pass", m_pass, 1);

        fill_good();
        b_last[15] = 1'b1;
        run_burst(3, 0, -1, -1);
        chk("early_rlast_proto", m_proto, 1);
        chk("early_rlast_rready", m_rready, 0);

        fill_good();
        b_last[31] = 1'b0;
        run_burst(1, 0, -1, -1);
        chk("missing_rlast_proto", m_proto, 1);
        chk("missing_rlast_pass", m_pass, 0);

        fill_good();
        run_burst(1, 0, 3, -1);
        chk("restart_pass", m_pass, 1);

        fill_good();
        b_data[2] = 16'hDEAD;
        run_burst(1, 0, -1, 10);
        chk("after_abort_busy", m_busy, 0);
        fill_good();
        run_burst(2, 0, -1, -1);
        chk("after_abort_pass", m_pass, 1);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_burst(int'($urandom_range(0, 4)), 2, -1, -1);
        end

        sel = 1;
        fill_good();
        run_burst(1, 2, -1, -1);
        chk("wrap_pass", m_pass, 1);

        fill_good();
        for (int i = 0; i < 256; i++) b_data[i] = ~b_data[i];
        run_burst(0, 0, -1, -1);
        chk("sat_err", m_err, 255);
        chk("sat_pass", m_pass, 0);

        fill_random();
        run_burst(2, 2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
